// File: rtl/data_sram_like_responder_pkg.sv
// Shared constants for the sram-like data responder: access-size encodings,
// default geometry, and width helpers used by the top and its response queue.
package data_sram_like_responder_pkg;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } size_e;

   localparam int DEFAULT_AW      = 14;
   localparam int DEFAULT_DEPTH   = 4;
   localparam int DEFAULT_LATENCY = 2;

   // Entries store LATENCY-1 as their starting age, so $clog2(LATENCY) bits suffice.
   function automatic int age_width(input int latency);
      return (latency < 2) ? 1 : $clog2(latency);
   endfunction

endpackage

// File: rtl/data_sram_like_responder_resp_fifo.sv
// In-order outstanding-request queue: each entry holds {wr, age, data}; ages count
// down every cycle while valid and saturate at zero until the head is popped.
module sram_like_resp_fifo
   import data_sram_like_responder_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AGE_W = 1,
   parameter int DW    = 32
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         push,
   input  logic                         push_wr,
   input  logic [AGE_W-1:0]             push_age,
   input  logic [DW-1:0]                push_data,
   input  logic                         pop,
   output logic                         head_valid,
   output logic                         head_wr,
   output logic [AGE_W-1:0]             head_age,
   output logic [DW-1:0]                head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count_next
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [DEPTH-1:0] valid_vec;
   logic [AGE_W-1:0] age_arr [DEPTH];
   logic [DW:0]      mem [DEPTH];

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
      end
   end

   // Payload needs no reset: an entry is only ever read while its valid bit is set.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= {push_wr, push_data};
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic             valid_reg;
      logic [AGE_W-1:0] age_reg;
      logic             hit_push;
      logic             hit_pop;

      assign hit_push = push && (wr_ptr_reg == PTR_W'(gi));
      assign hit_pop  = pop  && (rd_ptr_reg == PTR_W'(gi));

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            valid_reg <= 1'b0;
            age_reg   <= '0;
         end else if (hit_push) begin
            valid_reg <= 1'b1;
            age_reg   <= push_age;
         end else begin
            if (hit_pop) valid_reg <= 1'b0;
            if (valid_reg && (age_reg != '0)) age_reg <= age_reg - 1'b1;
         end
      end

      assign valid_vec[gi] = valid_reg;
      assign age_arr[gi]   = age_reg;
   end

   assign head_valid           = valid_vec[rd_ptr_reg];
   assign head_age             = age_arr[rd_ptr_reg];
   assign {head_wr, head_data} = mem[rd_ptr_reg];

endmodule

// File: rtl/data_sram_like_responder.sv
// Responder end of the sram-like data interface: word RAM, in-order response queue
// and registered addr_ok/data_ok/rdata with a fixed accept-to-data_ok latency.
module data_sram_like_responder
   import data_sram_like_responder_pkg::*;
#(
   parameter int AW      = DEFAULT_AW,
   parameter int DEPTH   = DEFAULT_DEPTH,
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   input  logic        resp_hold,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int AGE_W = age_width(LATENCY);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [31:0]      ram [0:(2**AW)-1];
   logic [AW-1:0]    word_idx;
   logic             accept;
   logic             retire;
   logic [31:0]      push_data;
   logic             head_valid;
   logic             head_wr;
   logic [AGE_W-1:0] head_age;
   logic [31:0]      head_data;
   logic [CNT_W-1:0] count_next;
   logic             addr_ok_reg;
   logic             data_ok_reg;
   logic [31:0]      rdata_reg;
   logic             unused_bits;

   // Lane strobes alone select the written bytes; size is carried for tracing only.
   assign unused_bits = ^{size, addr[31:AW+2], addr[1:0]};

   assign word_idx = addr[AW+1:2];
   assign accept   = req && addr_ok_reg;
   assign retire   = head_valid && (head_age == '0) && !resp_hold;

   always_ff @(posedge clk) begin
      if (accept && wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) ram[word_idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // Read data is captured into the queue entry on the accept edge, so any write
   // accepted on an earlier edge is already visible.
   assign push_data = wr ? 32'h0 : ram[word_idx];

   sram_like_resp_fifo #(
      .DEPTH (DEPTH),
      .AGE_W (AGE_W),
      .DW    (32)
   ) u_fifo (
      .clk        (clk),
      .resetn     (resetn),
      .push       (accept),
      .push_wr    (wr),
      .push_age   (AGE_W'(LATENCY - 1)),
      .push_data  (push_data),
      .pop        (retire),
      .head_valid (head_valid),
      .head_wr    (head_wr),
      .head_age   (head_age),
      .head_data  (head_data),
      .count_next (count_next)
   );

   // addr_ok_reg doubles as the reset-release flop: it stays low for the first
   // cycle after resetn rises and then tracks the queue's free space.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_ok_reg <= 1'b0;
         data_ok_reg <= 1'b0;
         rdata_reg   <= 32'h0;
      end else begin
         addr_ok_reg <= (count_next < CNT_W'(DEPTH));
         data_ok_reg <= retire;
         rdata_reg   <= (retire && !head_wr) ? head_data : 32'h0;
      end
   end

   assign addr_ok = addr_ok_reg;
   assign data_ok = data_ok_reg;
   assign rdata   = rdata_reg;

endmodule

// File: tb/tb_data_sram_like_responder.sv
// Directed bench for data_sram_like_responder: ordering, latency, byte strobes,
// throughput, back-pressure, asynchronous reset and read-after-write.
module tb_data_sram_like_responder;
   import data_sram_like_responder_pkg::*;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  size = 2'd2;
   logic [31:0] addr = 32'h0;
   logic [3:0]  wstrb = 4'h0;
   logic [31:0] wdata = 32'h0;
   logic        resp_hold = 1'b0;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int          dok_cyc[$];
   logic [31:0] dok_data[$];
   int          acc_cyc[$];

   data_sram_like_responder dut (
      .clk       (clk),
      .resetn    (resetn),
      .req       (req),
      .wr        (wr),
      .size      (size),
      .addr      (addr),
      .wstrb     (wstrb),
      .wdata     (wdata),
      .resp_hold (resp_hold),
      .addr_ok   (addr_ok),
      .data_ok   (data_ok),
      .rdata     (rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log edge numbers: an accept at negedge happens on the next edge; data_ok seen
   // at negedge was raised by the edge just passed.
   always @(negedge clk) begin
      if (data_ok === 1'b1) begin
         dok_cyc.push_back(cyc);
         dok_data.push_back(rdata);
      end
      if (resetn && req && (addr_ok === 1'b1)) acc_cyc.push_back(cyc + 1);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      req   = r;
      wr    = w;
      addr  = a;
      wdata = d;
      wstrb = s;
      size  = SIZE_W;
   endtask

   task automatic idle(input int n);
      set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (n) tick();
   endtask

   task automatic clear_log();
      dok_cyc.delete();
      dok_data.delete();
      acc_cyc.delete();
   endtask

   task automatic test_reset();
      #12;
      n_cmp++; if (addr_ok !== 1'b0) begin n_bad++; $display("FAIL reset_addr_ok: got %b want 0", addr_ok); end
      n_cmp++; if (data_ok !== 1'b0) begin n_bad++; $display("FAIL reset_data_ok: got %b want 0", data_ok); end
      n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      n_cmp++; if (addr_ok !== 1'b0) begin n_bad++; $display("FAIL release_first_cycle: addr_ok %b want 0", addr_ok); end
      tick();
      n_cmp++; if (addr_ok !== 1'b1) begin n_bad++; $display("FAIL release_second_cycle: addr_ok %b want 1", addr_ok); end
   endtask

   task automatic test_write_read();
      clear_log();
      set_req(1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 4'hF); tick();
      set_req(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);         tick();
      idle(6);
      n_cmp++; if (dok_cyc.size() != 2 || acc_cyc.size() != 2) begin
         n_bad++; $display("FAIL wr_rd_count: data_ok %0d accepts %0d want 2/2", dok_cyc.size(), acc_cyc.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            n_cmp++; if (dok_cyc[i] - acc_cyc[i] != LAT) begin
               n_bad++; $display("FAIL wr_rd_latency[%0d]: got %0d want %0d", i, dok_cyc[i] - acc_cyc[i], LAT);
            end
         end
         n_cmp++; if (dok_data[0] !== 32'h0) begin n_bad++; $display("FAIL wr_rd_write_rdata: got %h want 0", dok_data[0]); end
         n_cmp++; if (dok_data[1] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_rd_read_rdata: got %h want deadbeef", dok_data[1]); end
      end
      $display("write_read: data_ok pulses %0d", dok_cyc.size());
   endtask

   task automatic test_byte_write();
      clear_log();
      set_req(1'b1, 1'b1, 32'h1000, 32'h11223344, 4'hF); tick();
      set_req(1'b1, 1'b1, 32'h1003, 32'hAAAAAAAA, 4'h8); tick();
      set_req(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);         tick();
      idle(6);
      n_cmp++; if (dok_data.size() != 3) begin
         n_bad++; $display("FAIL byte_count: got %0d want 3", dok_data.size());
      end else begin
         n_cmp++; if (dok_data[1] !== 32'h0) begin n_bad++; $display("FAIL byte_write_rdata: got %h want 0", dok_data[1]); end
         n_cmp++; if (dok_data[2] !== 32'hAA223344) begin n_bad++; $display("FAIL byte_merge: got %h want aa223344", dok_data[2]); end
      end
      $display("byte_write: read 0x1000");
   endtask

   task automatic test_back_to_back();
      clear_log();
      for (int i = 0; i < 12; i++) begin
         n_cmp++; if (addr_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_addr_ok[%0d]: got %b want 1", i, addr_ok); end
         if (i < 6) set_req(1'b1, 1'b1, 32'h4000 + 32'(4*i), 32'h0A0B0C00 + 32'(i), 4'hF);
         else       set_req(1'b1, 1'b0, 32'h4000 + 32'(4*(i-6)), 32'h0, 4'h0);
         tick();
      end
      idle(6);
      n_cmp++; if (dok_cyc.size() != 12 || acc_cyc.size() != 12) begin
         n_bad++; $display("FAIL b2b_count: data_ok %0d accepts %0d want 12/12", dok_cyc.size(), acc_cyc.size());
      end else begin
         for (int i = 1; i < 12; i++) begin
            n_cmp++; if (dok_cyc[i] != dok_cyc[0] + i) begin
               n_bad++; $display("FAIL b2b_consecutive[%0d]: edge %0d want %0d", i, dok_cyc[i], dok_cyc[0] + i);
            end
         end
         for (int i = 0; i < 6; i++) begin
            n_cmp++; if (dok_data[6+i] !== 32'h0A0B0C00 + 32'(i)) begin
               n_bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, dok_data[6+i], 32'h0A0B0C00 + 32'(i));
            end
         end
      end
      $display("back_to_back: %0d accepts, %0d data_ok", acc_cyc.size(), dok_cyc.size());
   endtask

   task automatic test_hold();
      clear_log();
      resp_hold = 1'b1;
      set_req(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
      repeat (10) tick();
      n_cmp++; if (acc_cyc.size() != 4) begin n_bad++; $display("FAIL hold_accepts: got %0d want 4", acc_cyc.size()); end
      n_cmp++; if (addr_ok !== 1'b0) begin n_bad++; $display("FAIL hold_full_addr_ok: got %b want 0", addr_ok); end
      n_cmp++; if (dok_cyc.size() != 0) begin n_bad++; $display("FAIL hold_data_ok: got %0d pulses want 0", dok_cyc.size()); end
      resp_hold = 1'b0;
      set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      n_cmp++; if (data_ok !== 1'b1) begin n_bad++; $display("FAIL hold_release_data_ok: got %b want 1", data_ok); end
      n_cmp++; if (addr_ok !== 1'b1) begin n_bad++; $display("FAIL hold_release_addr_ok: got %b want 1", addr_ok); end
      idle(6);
      n_cmp++; if (dok_cyc.size() != 4) begin
         n_bad++; $display("FAIL hold_drain_count: got %0d want 4", dok_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++; if (dok_cyc[i] != dok_cyc[0] + i || dok_data[i] !== 32'hAA223344) begin
               n_bad++; $display("FAIL hold_drain[%0d]: edge %0d data %h want edge %0d data aa223344",
                                 i, dok_cyc[i], dok_data[i], dok_cyc[0] + i);
            end
         end
      end
      $display("hold: drained %0d", dok_cyc.size());
   endtask

   task automatic test_reset_mid();
      set_req(1'b1, 1'b1, 32'h2000, 32'h5A5A1234, 4'hF); tick();
      idle(5);
      clear_log();
      resp_hold = 1'b1;
      repeat (3) begin
         set_req(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0);
         tick();
      end
      idle(3);
      resp_hold = 1'b0;
      tick();
      n_cmp++; if (data_ok !== 1'b1 || rdata !== 32'h5A5A1234) begin
         n_bad++; $display("FAIL mid_first_pop: data_ok %b rdata %h want 1 5a5a1234", data_ok, rdata);
      end
      #1 resetn = 1'b0;
      #1;
      n_cmp++; if (addr_ok !== 1'b0) begin n_bad++; $display("FAIL mid_async_addr_ok: got %b want 0", addr_ok); end
      n_cmp++; if (data_ok !== 1'b0) begin n_bad++; $display("FAIL mid_async_data_ok: got %b want 0", data_ok); end
      n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL mid_async_rdata: got %h want 0", rdata); end
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      clear_log();
      @(negedge clk);
      n_cmp++; if (addr_ok !== 1'b0) begin n_bad++; $display("FAIL mid_release_first: addr_ok %b want 0", addr_ok); end
      tick();
      n_cmp++; if (addr_ok !== 1'b1) begin n_bad++; $display("FAIL mid_release_second: addr_ok %b want 1", addr_ok); end
      idle(8);
      n_cmp++; if (dok_cyc.size() != 0) begin n_bad++; $display("FAIL mid_stale_data_ok: got %0d pulses want 0", dok_cyc.size()); end
      clear_log();
      set_req(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0); tick();
      idle(5);
      n_cmp++; if (dok_data.size() != 1 || dok_data[0] !== 32'h5A5A1234) begin
         n_bad++; $display("FAIL mid_persist: pulses %0d data %h want 1 5a5a1234", dok_data.size(),
                           (dok_data.size() > 0) ? dok_data[0] : 32'h0);
      end
      $display("reset_mid: post-reset read done");
   endtask

   task automatic test_raw();
      set_req(1'b1, 1'b1, 32'h3000, 32'h11111111, 4'hF); tick();
      idle(5);
      clear_log();
      set_req(1'b1, 1'b1, 32'h3000, 32'hCAFEF00D, 4'hF); tick();
      set_req(1'b1, 1'b0, 32'h3000, 32'h0, 4'h0);         tick();
      idle(6);
      n_cmp++; if (dok_data.size() != 2 || acc_cyc.size() != 2) begin
         n_bad++; $display("FAIL raw_count: data_ok %0d accepts %0d want 2/2", dok_data.size(), acc_cyc.size());
      end else begin
         n_cmp++; if (dok_data[1] !== 32'hCAFEF00D) begin n_bad++; $display("FAIL raw_rdata: got %h want cafef00d", dok_data[1]); end
         n_cmp++; if (dok_cyc[1] - acc_cyc[1] != LAT) begin
            n_bad++; $display("FAIL raw_latency: got %0d want %0d", dok_cyc[1] - acc_cyc[1], LAT);
         end
      end
      $display("raw: read 0x3000 after write");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_write();
      test_back_to_back();
      test_hold();
      test_reset_mid();
      test_raw();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
